// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// on operand magnitudes, with a one-cycle sign fix-up before the result is presented.
module alu_muldiv #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int STEPS = WIDTH / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [2:0]         op_reg;
  logic               a_neg_reg, b_neg_reg, special_reg;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic [WIDTH-1:0]   result_reg;

  // Operand decode for the accept cycle
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] spec_val;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    abs_a    = a_neg ? -a : a;
    abs_b    = b_neg ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      spec_val = op[1] ? a : '1;
    end else begin
      spec_val = op[1] ? '0 : a;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state; flush wins over accept and over a coincident out_ready
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: if (in_valid) state_next = special ? FIX : CALC;
        CALC: if (cnt_reg == CW'(1)) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    out_valid = (state_reg == DONE);
  end

  // UNROLL iterations of either shift-add multiply or restoring divide.
  // Divide mode keeps the quotient in the low half of prod_reg.
  always_comb begin
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rs;
    logic [WIDTH:0] diff;
    prod_next = prod_reg;
    rem_next  = rem_reg;
    sum       = '0;
    rs        = '0;
    diff      = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op_reg[2]) begin
        sum       = {1'b0, prod_next[2*WIDTH-1:WIDTH]} +
                    (prod_next[0] ? {1'b0, opnd_reg} : '0);
        prod_next = {sum, prod_next[WIDTH-1:1]};
      end else begin
        rs        = {rem_next, prod_next[WIDTH-1]};
        prod_next = {prod_next[2*WIDTH-1:WIDTH], prod_next[WIDTH-2:0], 1'b0};
        diff      = rs - {1'b0, opnd_reg};
        if (!diff[WIDTH]) begin
          rem_next     = diff[WIDTH-1:0];
          prod_next[0] = 1'b1;
        end else begin
          rem_next = rs[WIDTH-1:0];
        end
      end
    end
  end

  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot, fix_val;

  always_comb begin
    prod_signed = (a_neg_reg ^ b_neg_reg) ? -prod_reg : prod_reg;
    quot        = prod_reg[WIDTH-1:0];
    if (special_reg) begin
      fix_val = prod_reg[WIDTH-1:0];
    end else if (op_reg == OP_MUL) begin
      fix_val = prod_signed[WIDTH-1:0];
    end else if (!op_reg[2]) begin
      fix_val = prod_signed[2*WIDTH-1:WIDTH];
    end else if (!op_reg[1]) begin
      fix_val = (a_neg_reg ^ b_neg_reg) ? -quot : quot;
    end else begin
      fix_val = a_neg_reg ? -rem_reg : rem_reg;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg     <= '0;
      op_reg      <= '0;
      a_neg_reg   <= 1'b0;
      b_neg_reg   <= 1'b0;
      special_reg <= 1'b0;
      prod_reg    <= '0;
      rem_reg     <= '0;
      opnd_reg    <= '0;
      result_reg  <= '0;
    end else if (flush) begin
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg      <= op;
            a_neg_reg   <= a_neg;
            b_neg_reg   <= b_neg;
            special_reg <= special;
            cnt_reg     <= CW'(STEPS);
            rem_reg     <= '0;
            opnd_reg    <= op[2] ? abs_b : abs_a;
            prod_reg    <= {{WIDTH{1'b0}}, special ? spec_val : (op[2] ? abs_a : abs_b)};
          end
        end
        CALC: begin
          prod_reg <= prod_next;
          rem_reg  <= rem_next;
          cnt_reg  <= cnt_reg - CW'(1);
        end
        FIX:     result_reg <= fix_val;
        default: ;
      endcase
    end
  end

  assign result = result_reg;

endmodule
